// File: rtl/apb_to_obi_bridge.sv
// -----------------------------------------------------------------------------
// apb_to_obi_bridge
//   APB completer that turns each single APB transfer into one OBI manager
//   transaction. An external APB manager reaches core-side memory and
//   peripherals through the OBI crossbar. One transfer is in flight at a time.
//
// Ports
//   clk_i, rst_ni          shared core clock, asynchronous active-low reset
//   psel_i .. pstrb_i      APB request (select, enable, write, addr, data, strobes)
//   prdata_o, pready_o,
//   pslverr_o              APB response, valid only while pready_o=1
//   obi_req_o .. obi_wdata_o  OBI address phase (all registered)
//   obi_gnt_i              OBI grant
//   obi_rvalid_i, obi_rdata_i, obi_err_i  OBI response phase
// -----------------------------------------------------------------------------
module apb_to_obi_bridge #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [AddrWidth-1:0]   paddr_i,
    input  logic [DataWidth-1:0]   pwdata_i,
    input  logic [DataWidth/8-1:0] pstrb_i,
    output logic [DataWidth-1:0]   prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [DataWidth/8-1:0] obi_be_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    input  logic                   obi_rvalid_i,
    input  logic [DataWidth-1:0]   obi_rdata_i,
    input  logic                   obi_err_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } state_e;

    state_e                 state_q,     state_d;
    logic                   obi_req_q,   obi_req_d;
    logic [AddrWidth-1:0]   obi_addr_q,  obi_addr_d;
    logic                   obi_we_q,    obi_we_d;
    logic [DataWidth/8-1:0] obi_be_q,    obi_be_d;
    logic [DataWidth-1:0]   obi_wdata_q, obi_wdata_d;
    logic                   pready_q,    pready_d;
    logic                   pslverr_q,   pslverr_d;
    logic [DataWidth-1:0]   prdata_q,    prdata_d;

    always_comb begin
        state_d     = state_q;
        obi_req_d   = obi_req_q;
        obi_addr_d  = obi_addr_q;
        obi_we_d    = obi_we_q;
        obi_be_d    = obi_be_q;
        obi_wdata_d = obi_wdata_q;
        pready_d    = pready_q;
        pslverr_d   = pslverr_q;
        prdata_d    = prdata_q;

        case (state_q)
            IDLE: begin
                // Only the setup phase starts a transfer; responses arriving
                // here are leftovers from an aborted access and are dropped.
                if (psel_i && !penable_i) begin
                    if (paddr_i[1:0] != 2'b00) begin
                        state_d   = DONE;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                    end else begin
                        state_d     = REQ;
                        obi_req_d   = 1'b1;
                        obi_addr_d  = {paddr_i[AddrWidth-1:2], 2'b00};
                        obi_we_d    = pwrite_i;
                        obi_wdata_d = pwdata_i;
                        obi_be_d    = pwrite_i ? pstrb_i : '1;
                    end
                end
            end
            REQ: begin
                if (obi_gnt_i) begin
                    state_d   = RSP;
                    obi_req_d = 1'b0;
                end
            end
            RSP: begin
                if (obi_rvalid_i) begin
                    state_d   = DONE;
                    pready_d  = 1'b1;
                    pslverr_d = obi_err_i;
                    // Read data is returned only for successful reads.
                    prdata_d  = (obi_we_q || obi_err_i) ? '0 : obi_rdata_i;
                end
            end
            DONE: begin
                // Completes regardless of psel_i so an early-dropped
                // transfer cannot hang the bridge.
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
            default: begin
                state_d   = IDLE;
                obi_req_d = 1'b0;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            obi_req_q   <= 1'b0;
            obi_addr_q  <= '0;
            obi_we_q    <= 1'b0;
            obi_be_q    <= '0;
            obi_wdata_q <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            obi_req_q   <= obi_req_d;
            obi_addr_q  <= obi_addr_d;
            obi_we_q    <= obi_we_d;
            obi_be_q    <= obi_be_d;
            obi_wdata_q <= obi_wdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            prdata_q    <= prdata_d;
        end
    end

    assign obi_req_o   = obi_req_q;
    assign obi_addr_o  = obi_addr_q;
    assign obi_we_o    = obi_we_q;
    assign obi_be_o    = obi_be_q;
    assign obi_wdata_o = obi_wdata_q;
    assign pready_o    = pready_q;
    assign pslverr_o   = pslverr_q;
    assign prdata_o    = prdata_q;

endmodule

// File: tb/tb_apb_to_obi_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_to_obi_bridge
//   Drives APB transfers and a scripted OBI subordinate. For each transfer the
//   bench derives, from the grant delay g and response delay r, the cycle-by-
//   cycle expected outputs (request window, pready cycle, response values);
//   one negedge process compares the DUT against those expectations.
// -----------------------------------------------------------------------------
module tb_apb_to_obi_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        obi_req, obi_we;
    logic        obi_gnt = 1'b0;
    logic [31:0] obi_addr, obi_wdata;
    logic [3:0]  obi_be;
    logic        obi_rvalid = 1'b0, obi_err = 1'b0;
    logic [31:0] obi_rdata = '0;

    apb_to_obi_bridge #(.AddrWidth(32), .DataWidth(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
        .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr),
        .obi_we_o(obi_we), .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
        .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata), .obi_err_i(obi_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for the current cycle
    logic        chk_en = 1'b0;
    logic        exp_req = 1'b0, exp_pready = 1'b0, exp_pslverr = 1'b0;
    logic [31:0] exp_prdata = '0, exp_addr = '0, exp_wdata = '0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_be = '0;

    // Observations for literal pins
    int          grants = 0, preadys = 0, req_cycles = 0, pready_cyc = 0;
    logic [31:0] last_addr = '0, last_prdata = '0;
    logic        last_pslverr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("obi_req", 32'(obi_req), 32'(exp_req));
            check("pready", 32'(pready), 32'(exp_pready));
            check("pslverr", 32'(pslverr), 32'(exp_pslverr));
            check("prdata", prdata, exp_prdata);
            if (exp_req) begin
                check("obi_addr", obi_addr, exp_addr);
                check("obi_we", 32'(obi_we), 32'(exp_we));
                check("obi_be", 32'(obi_be), 32'(exp_be));
                check("obi_wdata", obi_wdata, exp_wdata);
            end
            if (obi_req) req_cycles++;
            if (obi_req && obi_gnt) begin
                grants++;
                last_addr = obi_addr;
            end
            if (pready) begin
                preadys++;
                pready_cyc   = cyc;
                last_prdata  = prdata;
                last_pslverr = pslverr;
            end
        end
    end

    task automatic clear_exp();
        exp_req = 1'b0; exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = '0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            psel = 1'b0; penable = 1'b0; obi_gnt = 1'b0;
            // Stray responses while idle must be ignored.
            obi_rvalid = 1'($urandom_range(0, 1));
            obi_rdata = $urandom; obi_err = 1'($urandom_range(0, 1));
            clear_exp();
            @(posedge clk); #1;
        end
        obi_rvalid = 1'b0;
    endtask

    // One APB transfer; g = REQ cycles without grant, r = RSP cycles without rvalid.
    int setup_cyc = 0;
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int unsigned g, input int unsigned r,
                        input logic [31:0] rdata, input logic err, input logic drop);
        logic        mis;
        int unsigned t;
        mis = (addr[1:0] != 2'b00);
        t   = mis ? 1 : g + r + 3;
        psel = 1'b1; penable = 1'b0; pwrite = we; paddr = addr; pwdata = wdata; pstrb = strb;
        obi_gnt = 1'b0;
        obi_rvalid = 1'($urandom_range(0, 1));
        obi_rdata = $urandom; obi_err = 1'b0;
        clear_exp();
        setup_cyc = cyc;
        @(posedge clk); #1;
        for (int unsigned k = 1; k <= t; k++) begin
            penable = 1'b1;
            if (drop && k >= 2) begin psel = 1'b0; penable = 1'b0; end
            exp_req   = !mis && (k <= g + 1);
            exp_addr  = {addr[31:2], 2'b00};
            exp_we    = we;
            exp_be    = we ? strb : 4'hF;
            exp_wdata = wdata;
            obi_gnt    = !mis && (k == g + 1);
            obi_rvalid = !mis && (k == g + 2 + r);
            obi_rdata  = obi_rvalid ? rdata : $urandom;
            obi_err    = obi_rvalid ? err : 1'($urandom_range(0, 1));
            exp_pready  = (k == t);
            exp_pslverr = (k == t) && (mis || err);
            exp_prdata  = ((k == t) && !mis && !we && !err) ? rdata : 32'h0;
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0; obi_gnt = 1'b0; obi_rvalid = 1'b0;
        clear_exp();
    endtask

    int g0, p0, q0;
    logic [31:0] a;

    initial begin
        #23;
        check("reset obi_req", 32'(obi_req), 32'h0);
        check("reset obi_addr", obi_addr, 32'h0);
        check("reset obi_be", 32'(obi_be), 32'h0);
        check("reset obi_wdata", obi_wdata, 32'h0);
        check("reset obi_we", 32'(obi_we), 32'h0);
        check("reset pready", 32'(pready), 32'h0);
        check("reset pslverr", 32'(pslverr), 32'h0);
        check("reset prdata", prdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // 1: aligned read, gnt first REQ cycle, rvalid next -> pready in T3
        xfer(1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("t1 addr", last_addr, 32'h0000_1004);
        check("t1 prdata", last_prdata, 32'hDEAD_BEEF);
        check("t1 latency", 32'(pready_cyc - setup_cyc), 32'd3);

        // 2: write, gnt low for 5 cycles -> 6 REQ cycles
        q0 = req_cycles; p0 = preadys;
        xfer(1'b1, 32'h0000_2008, 32'hA5A5_0000, 4'hC, 5, 1, 32'h0, 1'b0, 1'b0);
        check("t2 req cycles", 32'(req_cycles - q0), 32'd6);
        check("t2 preadys", 32'(preadys - p0), 32'd1);
        idle(1);

        // 3: misaligned read -> no OBI request, error in T1
        q0 = req_cycles;
        xfer(1'b0, 32'h0000_1002, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        check("t3 req cycles", 32'(req_cycles - q0), 32'd0);
        check("t3 pslverr", 32'(last_pslverr), 32'd1);
        check("t3 latency", 32'(pready_cyc - setup_cyc), 32'd1);

        // 4: read error, then clean read
        xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 2, 32'h1111_2222, 1'b1, 1'b0);
        check("t4 err prdata", last_prdata, 32'h0);
        check("t4 err pslverr", 32'(last_pslverr), 32'd1);
        xfer(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 1, 32'h3333_4444, 1'b0, 1'b0);
        check("t4 next pslverr", 32'(last_pslverr), 32'd0);

        // 5: reset while waiting for rvalid, late rvalid ignored afterwards
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_3000;
        clear_exp();
        @(posedge clk); #1;
        penable = 1'b1; obi_gnt = 1'b1;
        exp_req = 1'b1; exp_addr = 32'h0000_3000; exp_we = 1'b0; exp_be = 4'hF;
        exp_wdata = pwdata;
        @(posedge clk); #1;
        obi_gnt = 1'b0; exp_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
        #1;
        check("t5 rst obi_req", 32'(obi_req), 32'h0);
        check("t5 rst pready", 32'(pready), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        obi_rvalid = 1'b1; obi_rdata = 32'hBAD0_BAD0; obi_err = 1'b1;
        @(posedge clk); #1;
        obi_rvalid = 1'b0; obi_err = 1'b0;
        idle(2);
        xfer(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1, 2, 32'h1234_5678, 1'b0, 1'b0);
        check("t5 fresh prdata", last_prdata, 32'h1234_5678);

        // 6: ten back-to-back writes, random delays
        g0 = grants; p0 = preadys;
        for (int i = 0; i < 10; i++) begin
            a = {$urandom_range(0, 32'h3FFF), 2'b00};
            xfer(1'b1, a, $urandom, 4'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                 32'h0, 1'b0, 1'b0);
        end
        check("t6 grants", 32'(grants - g0), 32'd10);
        check("t6 preadys", 32'(preadys - p0), 32'd10);

        // Random mix including misaligned, errors, early psel drop
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
